// File: rtl/bus_register.sv
//------------------------------------------------------------------------------
// Module      : bus_register
// Description : Edge-triggered storage register with asynchronous active-low
//               clear, active-low synchronous load and a tri-statable output.
//               This is the generic state element of the ESC64 datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_register #(
  parameter int          DATA_WIDTH  = 16,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  notLoad,
  input  logic                  outputEnable,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] out
);

  // Only the low DATA_WIDTH bits of the reset value are meaningful.
  localparam logic [DATA_WIDTH-1:0] c_reset_q = RESET_VALUE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] r_q;

  // Stored word: cleared asynchronously, loaded on a rising edge while notLoad is low.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_q <= c_reset_q;
    end else if (!notLoad) begin
      r_q <= in;
    end
  end

  // Bus driver: releases the shared bus whenever the output is not enabled.
  assign out = outputEnable ? r_q : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_bus_register.sv
//------------------------------------------------------------------------------
// Module      : tb_bus_register
// Description : Directed self-checking bench for bus_register. A 13-bit
//               instance covers reset, loading and microsequencer-style use;
//               a 16-bit instance with a truncated reset value covers hold,
//               tri-state, reset priority and reset release. The 16-bit bus
//               carries pull-ups so a released bus reads as all ones.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_register;

  logic        clock;
  logic        nr13, nl13, oe13;
  logic [12:0] in13;
  wire  [12:0] out13;
  logic        nr16, nl16, oe16;
  logic [15:0] in16;
  wire  [15:0] out16;

  int compared   = 0;
  int mismatched = 0;

  // Reset value is wider than the register; only 16'hA5C3 must survive.
  localparam logic [63:0] c_rv16 = 64'h0000_0001_A5C3;

  bus_register #(.DATA_WIDTH(13)) dut13 (
    .clock        (clock),
    .notReset     (nr13),
    .notLoad      (nl13),
    .outputEnable (oe13),
    .in           (in13),
    .out          (out13)
  );

  bus_register #(.DATA_WIDTH(16), .RESET_VALUE(c_rv16)) dut16 (
    .clock        (clock),
    .notReset     (nr16),
    .notLoad      (nl16),
    .outputEnable (oe16),
    .in           (in16),
    .out          (out16)
  );

  // Weak pull-ups make a released bus observable as 16'hFFFF.
  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (out16[i]);
  end

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nr13 = 1'b1; nl13 = 1'b1; oe13 = 1'b1; in13 = 13'h0000;
    nr16 = 1'b1; nl16 = 1'b1; oe16 = 1'b1; in16 = 16'h0000;

    // Asynchronous reset mid-cycle, no clock edge involved.
    #2;
    nr13 = 1'b0;
    nr16 = 1'b0;
    #1;
    check("rst13_async", 64'(out13), 64'h0000);
    check("rst16_trunc", 64'(out16), 64'hA5C3);

    // Reset held across three edges with a pending load.
    nl13 = 1'b0; in13 = 13'h1FFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst13_hold", 64'(out13), 64'h0000);
    end

    // Release between edges, then load.
    nr13 = 1'b1; in13 = 13'h0ABC;
    #2;
    check("rel13_no_edge", 64'(out13), 64'h0000);
    tick();
    check("load13_abc", 64'(out13), 64'h0ABC);
    in13 = 13'h0123;
    #3;
    check("load13_between", 64'(out13), 64'h0ABC);
    tick();
    check("load13_123", 64'(out13), 64'h0123);

    // Microsequencer use: permanently loading and driving.
    in13 = 13'h0000;
    tick();
    check("useq_0", 64'(out13), 64'h0000);
    in13 = 13'h0005;
    #2;
    check("useq_lag", 64'(out13), 64'h0000);
    tick();
    check("useq_5", 64'(out13), 64'h0005);
    in13 = 13'h1FFF;
    tick();
    check("useq_1fff", 64'(out13), 64'h1FFF);

    // 16-bit: load then hold.
    nr16 = 1'b1; nl16 = 1'b0; in16 = 16'hBEEF;
    tick();
    check("load16_beef", 64'(out16), 64'hBEEF);
    nl16 = 1'b1; in16 = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold16_beef", 64'(out16), 64'hBEEF);
    end

    // Tri-state: disable, load while disabled, re-enable without an edge.
    oe16 = 1'b0;
    #1;
    check("tri_off", 64'(out16), 64'hFFFF);
    nl16 = 1'b0; in16 = 16'h5555;
    tick();
    check("tri_load_hidden", 64'(out16), 64'hFFFF);
    nl16 = 1'b1;
    oe16 = 1'b1;
    #1;
    check("tri_on_5555", 64'(out16), 64'h5555);

    // Reset asserted at an edge while a load is requested: reset wins.
    nl16 = 1'b0; in16 = 16'hFFFF;
    @(posedge clock);
    nr16 = 1'b0;
    #1;
    check("prio_edge", 64'(out16), 64'hA5C3);
    tick();
    check("prio_held", 64'(out16), 64'hA5C3);

    // Release between edges has no effect until the next edge loads.
    in16 = 16'h0F0F;
    #2;
    nr16 = 1'b1;
    #1;
    check("rel16_no_edge", 64'(out16), 64'hA5C3);
    tick();
    check("rel16_load", 64'(out16), 64'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
